cve2_mac_datapath: RTL



---
 rtl/cve2_mac_datapath.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cve2_mac_datapath.sv
// Iterative shift-add MAC: (op_a*op_b)[31:0] + acc; CVE2_MAC_SATURATE_EN selects signed saturation.
// Latency: accept at E0, valid_o from cycle 32/BitsPerCycle + 2; all outputs registered.
// Backpressure: result held in DONE until ready_i; requests while busy are dropped, kill_i aborts.

package cve2_pkg;
    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;
endpackage

module cve2_mac_datapath #(
    parameter int BitsPerCycle = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mac_mul_en_i,
    input  cve2_pkg::md_op_e  md_operator_i,
    input  logic [31:0]       op_a_i,
    input  logic [31:0]       op_b_i,
    input  logic [31:0]       acc_i,
    input  logic              kill_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [31:0]       result_o,
    output logic              busy_o,
    output logic              sat_o
);

    localparam int K    = 32 / BitsPerCycle;
    localparam int CntW = $clog2(K);
    localparam logic [CntW-1:0] CntLast = CntW'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        ACC  = 2'b10,
        DONE = 2'b11
    } state_e;

    typedef struct packed {
        logic [31:0] mcand;
        logic [31:0] mplier;
        logic [31:0] addend;
    } mac_ops_t;

    state_e          state_q, state_d;
    mac_ops_t        ops_q;
    logic [31:0]     prod_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     result_q;
    logic [31:0]     pp_step;
    logic [31:0]     acc_sum;
    logic [31:0]     acc_result;
    logic            accept;

    assign accept = (state_q == IDLE) && mac_mul_en_i && !kill_i &&
                    (md_operator_i == cve2_pkg::MD_OP_MULL);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // kill_i outranks every other transition out of a busy state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = MUL;
            MUL: begin
                if (kill_i)                  state_d = IDLE;
                else if (cnt_q == CntLast)   state_d = ACC;
            end
            ACC:  state_d = kill_i ? IDLE : DONE;
            DONE: if (kill_i || ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Partial product of the multiplicand with the low BitsPerCycle multiplier bits
    always_comb begin
        pp_step = '0;
        for (int i = 0; i < BitsPerCycle; i++) begin
            if (ops_q.mplier[i]) pp_step = pp_step + (ops_q.mcand << i);
        end
    end

    assign acc_sum = prod_q + ops_q.addend;

`ifdef CVE2_MAC_SATURATE_EN
    logic acc_ovf;
    logic sat_q;

    // Signed overflow: same-sign operands producing a different-sign sum
    assign acc_ovf    = (prod_q[31] == ops_q.addend[31]) && (acc_sum[31] != prod_q[31]);
    assign acc_result = !acc_ovf ? acc_sum :
                        (ops_q.addend[31] ? 32'h8000_0000 : 32'h7FFF_FFFF);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_q <= 1'b0;
        end else if (state_q == ACC && !kill_i) begin
            sat_q <= acc_ovf;
        end
    end

    assign sat_o = sat_q;
`else
    assign acc_result = acc_sum;
    assign sat_o      = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ops_q    <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                ops_q.mcand  <= op_a_i;
                ops_q.mplier <= op_b_i;
                ops_q.addend <= acc_i;
                prod_q       <= '0;
                cnt_q        <= '0;
            end else if (state_q == MUL && !kill_i) begin
                prod_q       <= prod_q + pp_step;
                ops_q.mcand  <= ops_q.mcand << BitsPerCycle;
                ops_q.mplier <= ops_q.mplier >> BitsPerCycle;
                cnt_q        <= cnt_q + 1'b1;
            end
            if (state_q == ACC && !kill_i) begin
                result_q <= acc_result;
            end
        end
    end

    assign valid_o  = (state_q == DONE);
    assign busy_o   = (state_q != IDLE);
    assign result_o = result_q;

endmodule
